// File: rtl/exec_div_pkg.sv
// Shared execute-stage constants and the divider's local state encoding.
package exec_div_pkg;

    // Operand widths of the two 8086 divide forms.
    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    // exec_selwr select code that routes divOut onto the writeback bus.
    localparam logic [2:0] EXEC_SEL_DIV = 3'd4;

    // Interrupt vector raised on a divide error (INT 0).
    localparam logic [7:0] DIV_ERR_VEC = 8'd0;

    // Divider sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_t;

endpackage

// File: rtl/exec_div_if.sv
// Divider request/result bundle between the execute control and exec_div.
//
// Handshake: iStart is a one-cycle request that is accepted only while
// oBusy is low. oBusy rises the cycle after acceptance and stays high
// through the single-cycle oDone pulse. oQuot, oRem and oDivErr are valid
// with oDone and hold until the next accepted iStart.
interface exec_div_if
    import exec_div_pkg::*;
();
    logic                  iStart;
    logic                  iBW;
    logic                  iSgn;
    logic                  iSelRem;
    logic [2*WORD_W-1:0]   iDividend;
    logic [WORD_W-1:0]     iDivisor;
    logic                  oBusy;
    logic                  oDone;
    logic                  oDivErr;
    logic [WORD_W-1:0]     oQuot;
    logic [WORD_W-1:0]     oRem;
    logic [WORD_W-1:0]     oDivOut;
    div_state_t            dbg_state;

    modport master (
        output iStart, iBW, iSgn, iSelRem, iDividend, iDivisor,
        input  oBusy, oDone, oDivErr, oQuot, oRem, oDivOut, dbg_state
    );

    modport slave (
        input  iStart, iBW, iSgn, iSelRem, iDividend, iDivisor,
        output oBusy, oDone, oDivErr, oQuot, oRem, oDivOut, dbg_state
    );
endinterface

// File: rtl/exec_div_step.sv
// One combinational restoring-division step for byte or word operands.
module exec_div_step
    import exec_div_pkg::*;
(
    input  logic [WORD_W-1:0] iPrem,
    input  logic              iBit,
    input  logic [WORD_W-1:0] iDivisor,
    input  logic              iBW,
    output logic [WORD_W-1:0] oPrem,
    output logic              oQbit
);
    logic [WORD_W:0]   shift_w;
    logic [WORD_W-1:0] diff_w;
    logic              fit_w;
    logic [BYTE_W:0]   shift_b;
    logic [BYTE_W-1:0] diff_b;
    logic              fit_b;

    // Trial subtraction: the shifted remainder is one bit wider than the
    // divisor; when it fits, the difference is below the divisor so only the
    // low bits of the subtraction need to be kept.
    always_comb begin
        shift_w = {iPrem, iBit};
        fit_w   = (shift_w >= {1'b0, iDivisor});
        diff_w  = shift_w[WORD_W-1:0] - iDivisor;
        shift_b = {iPrem[BYTE_W-1:0], iBit};
        fit_b   = (shift_b >= {1'b0, iDivisor[BYTE_W-1:0]});
        diff_b  = shift_b[BYTE_W-1:0] - iDivisor[BYTE_W-1:0];
        if (iBW) begin
            oQbit = fit_w;
            oPrem = fit_w ? diff_w : shift_w[WORD_W-1:0];
        end else begin
            oQbit = fit_b;
            oPrem = {8'h00, (fit_b ? diff_b : shift_b[BYTE_W-1:0])};
        end
    end
endmodule

// File: rtl/exec_div.sv
// Iterative 8086 DIV/IDIV unit: one quotient bit per clock, result held
// stable for exec_selwr until the next accepted start.
module exec_div
    import exec_div_pkg::*;
(
    input  logic        iClk,
    input  logic        iRst,
    exec_div_if.slave   bus
);
    div_state_t        state, state_nxt;
    logic              bw_q, sgn_q, res_bw_q;
    logic [31:0]       dividend_q;
    logic [15:0]       divisor_q;
    logic [15:0]       prem_q, lo_q, dvs_q;
    logic [3:0]        cnt_q;
    logic              qneg_q, rneg_q;
    logic [15:0]       quot_q, rem_q;
    logic              err_q;

    logic              dvd_neg, dvs_neg;
    logic [31:0]       dvd_mag;
    logic [15:0]       dvs_mag, hi_mag, lo_mag;
    logic              load_err;
    logic              fix_err;
    logic [15:0]       quot_fix, rem_fix;
    logic [15:0]       step_prem;
    logic              step_qbit;

    // Signed operands reduced to magnitudes; overflow is caught up front
    // when the high half already meets or exceeds the divisor.
    always_comb begin
        dvd_neg = bw_q ? dividend_q[31] : dividend_q[15];
        dvs_neg = bw_q ? divisor_q[15] : divisor_q[7];
        if (bw_q) begin
            dvd_mag = (sgn_q && dvd_neg) ? -dividend_q : dividend_q;
            dvs_mag = (sgn_q && dvs_neg) ? -divisor_q : divisor_q;
            hi_mag  = dvd_mag[31:16];
            lo_mag  = dvd_mag[15:0];
        end else begin
            dvd_mag = {16'h0000, ((sgn_q && dvd_neg) ? -dividend_q[15:0] : dividend_q[15:0])};
            dvs_mag = {8'h00, ((sgn_q && dvs_neg) ? -divisor_q[7:0] : divisor_q[7:0])};
            hi_mag  = {8'h00, dvd_mag[15:8]};
            lo_mag  = {8'h00, dvd_mag[7:0]};
        end
        load_err = (dvs_mag == 16'h0000) || (hi_mag >= dvs_mag);
    end

    // IDIV range check and sign restoration; the remainder follows the
    // dividend's sign, and -32768 / -128 are rejected like the original part.
    always_comb begin
        if (bw_q) begin
            fix_err  = sgn_q && (lo_q > 16'h7FFF);
            quot_fix = qneg_q ? -lo_q : lo_q;
            rem_fix  = rneg_q ? -prem_q : prem_q;
        end else begin
            fix_err  = sgn_q && (lo_q[7:0] > 8'h7F);
            quot_fix = {8'h00, (qneg_q ? -lo_q[7:0] : lo_q[7:0])};
            rem_fix  = {8'h00, (rneg_q ? -prem_q[7:0] : prem_q[7:0])};
        end
    end

    exec_div_step u_div_step (
        .iPrem    (prem_q),
        .iBit     (bw_q ? lo_q[15] : lo_q[7]),
        .iDivisor (dvs_q),
        .iBW      (bw_q),
        .oPrem    (step_prem),
        .oQbit    (step_qbit)
    );

    // State register.
    always_ff @(posedge iClk) begin
        if (iRst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.iStart) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = load_err ? ST_DONE : ST_ITER;
            ST_ITER: if (cnt_q == 4'd0) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            bw_q       <= 1'b0;
            sgn_q      <= 1'b0;
            res_bw_q   <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            prem_q     <= '0;
            lo_q       <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.iStart) begin
                        bw_q       <= bus.iBW;
                        sgn_q      <= bus.iSgn;
                        dividend_q <= bus.iDividend;
                        divisor_q  <= bus.iDivisor;
                        err_q      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (load_err) begin
                        err_q <= 1'b1;
                    end else begin
                        prem_q <= hi_mag;
                        lo_q   <= lo_mag;
                        dvs_q  <= dvs_mag;
                        cnt_q  <= bw_q ? 4'd15 : 4'd7;
                        qneg_q <= sgn_q && (dvd_neg ^ dvs_neg);
                        rneg_q <= sgn_q && dvd_neg;
                    end
                end
                ST_ITER: begin
                    prem_q <= step_prem;
                    lo_q   <= bw_q ? {lo_q[14:0], step_qbit} : {8'h00, lo_q[6:0], step_qbit};
                    cnt_q  <= cnt_q - 4'd1;
                end
                ST_FIX: begin
                    if (fix_err) begin
                        err_q <= 1'b1;
                    end else begin
                        quot_q   <= quot_fix;
                        rem_q    <= rem_fix;
                        res_bw_q <= bw_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status decode and the unregistered result bus toward exec_selwr.
    always_comb begin
        bus.oBusy     = (state != ST_IDLE);
        bus.oDone     = (state == ST_DONE);
        bus.oDivErr   = err_q;
        bus.oQuot     = quot_q;
        bus.oRem      = rem_q;
        bus.dbg_state = state;
        if (res_bw_q) bus.oDivOut = bus.iSelRem ? rem_q : quot_q;
        else          bus.oDivOut = {rem_q[7:0], quot_q[7:0]};
    end
endmodule

// File: doc/exec_div.md
# exec_div

Iterative 8086 DIV/IDIV unit in the execute stage, one quotient bit per clock. It takes the dividend (AX or DX:AX) and divisor when `exec_selwr` has not yet selected a result. It produces quotient, remainder and a divide-error flag. Its `oDivOut` drives the `divOut` input of `exec_selwr` (select code 4). `exec_selwr` does not register `divOut`, so the value must stay stable until the next start.

## Interface
- No parameters; byte/word widths are fixed constants (see Structure).
- iClk  in  1  system clock; all state changes on rising edge.
- iRst  in  1  synchronous, active-high reset.
- iStart  in  1  start pulse; honoured only while idle.
- iBW  in  1  0 = byte (AX / r8), 1 = word (DX:AX / r16).
- iSgn  in  1  0 = DIV, 1 = IDIV.
- iSelRem  in  1  word mode: 0 = `oDivOut` shows quotient, 1 = remainder; sampled every cycle.
- iDividend  in  32  {DX,AX}; byte mode uses [15:0] only.
- iDivisor  in  16  divisor; byte mode uses [7:0] only.
- oBusy  out  1  operation in progress.
- oDone  out  1  one-cycle completion pulse.
- oDivErr  out  1  divide error (INT 0 request), valid with `oDone`, held until next start.
- oQuot  out  16  quotient; byte mode zero-extended.
- oRem  out  16  remainder; byte mode zero-extended.
- oDivOut  out  16  result bus:
  - byte mode: {rem[7:0], quot[7:0]} (AH:AL);
  - word mode: `iSelRem` ? rem : quot.

## Operation
- States: IDLE, LOAD, ITER, FIX, DONE.
- IDLE:
  - `iStart` latches `iBW`, `iSgn`, dividend and divisor, then moves to LOAD.
  - `iStart` in any other state is ignored.
- LOAD:
  - If signed, take the magnitudes of dividend and divisor. Record qneg = sign(dividend) XOR sign(divisor) and rneg = sign(dividend).
  - Error goes straight to DONE with `oDivErr`=1 when:
    - the divisor is 0, or
    - the magnitude high half (word [31:16], byte [15:8]) ≥ the divisor magnitude.
  - Otherwise move to ITER with count = N−1, where N = 16 for word and 8 for byte.
- ITER: one restoring step per cycle.
  - Shift partial remainder and dividend left by 1.
  - Trial subtraction is 17-bit for word, 9-bit for byte.
  - If no borrow, keep the difference and set the quotient LSB to 1.
  - Decrement count; leave for FIX after the count = 0 step.
- FIX:
  - For IDIV, a quotient magnitude above 0x7FFF (word) or 0x7F (byte) is an error. Negative limits are equal (8086 behaviour, so −32768 / −128 is rejected).
  - Negate the quotient if qneg and the remainder if rneg; the remainder always takes the dividend's sign.
  - Move to DONE.
- DONE: `oDone`=1 for one cycle, then IDLE.
  - On error, `oQuot` and `oRem` keep their pre-start values, and the error is reported by `oDivErr` only.
- `oQuot`, `oRem` and `oDivErr` update only in FIX/DONE and hold until the next accepted start.
- Reset values: state IDLE; `oBusy`, `oDone`, `oDivErr` = 0; `oQuot`, `oRem`, `oDivOut` = 0.
- Reset during any state aborts the operation immediately; no `oDone` pulse is produced.

## Timing
- Start edge = cycle 0.
- `oBusy`: high from cycle 1 through the cycle of `oDone` inclusive; low in IDLE.
- Normal completion: `oDone` in cycle N+3 (word 19, byte 11).
- LOAD-detected error: `oDone` in cycle 2.
- `iStart` in the `oDone` cycle is ignored; the earliest next start is the cycle after `oDone`.
- `oDivOut` is combinational from the result registers and `iSelRem` only, with no path from iDividend/iDivisor.

## Structure
- Shared execute package/include: byte/word width constants, `exec_selwr` select code 4 for divide, and divide-error vector number 0.
- State encoding is local to this block.
- One natural sub-module: `div_step`, a combinational restoring step (partial remainder, dividend bits, divisor, BW → new remainder, quotient bit). It is instantiated once and reused every ITER cycle.

## Test plan
- Unsigned byte:
  - Stimulus: AX=0x0064, divisor 0x07.
  - Required: `oDone` at cycle 11; quot 0x000E, rem 0x0002, `oDivOut`=0x020E, no error.
- Unsigned word:
  - Stimulus: DX:AX=0x0001_0000, divisor 0x0003.
  - Required: `oDone` at cycle 19; quot 0x5555, rem 0x0001; `oDivOut` follows `iSelRem` (0x5555 / 0x0001).
- Signed byte:
  - Stimulus: AX=0xFF9C (−100), divisor 0x07.
  - Required: quot 0xF2 (−14), rem 0xFE (−2), `oDivOut`=0xFEF2.
  - Repeat with divisor 0xF9 (−7): quot 0x0E, rem 0xFE.
- Error cases:
  - Divisor 0 → `oDivErr`=1, `oDone` at cycle 2, `oQuot` unchanged.
  - Unsigned DX:AX=0x0005_0000 / 0x0005 → error at cycle 2.
  - Signed 0xFFFF_8000 / 0x0001 → error detected in FIX, `oDone` at cycle 19.
- Reset and handshake:
  - Assert `iRst` in ITER cycle 5 → next cycle `oBusy`=0, `oDone`=0 and outputs are 0.
  - `iStart` pulses during busy are ignored; results match a single clean run.
